paddsb_seq: RTL
===============

PADDSB_SEQ -- requirements
Module: paddsb_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all state.
REQ-002 rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-003 start  input  1  request to begin a PADDSB operation; sampled each clk edge.
REQ-004 A  input  16  operand A: four signed 4-bit lanes, lane k = A[4k+3:4k].
REQ-005 B  input  16  operand B: same lane layout as A.
REQ-006 busy  output  1  high while a lane computation is in progress.
REQ-007 done  output  1  one-cycle pulse when Sum/Error are valid.
REQ-008 Sum  output  16  saturated per-lane result.
REQ-009 Error  output  1  OR of all four lane overflow flags for the last completed operation.

Function
REQ-010 The block SHALL contain exactly one 4-bit signed saturating adder, time-shared across the four lanes, lane 0 first.
REQ-011 States SHALL be IDLE, CALC and DONE, with a 2-bit lane counter cnt.
REQ-012 In IDLE or DONE, start=1 at an edge SHALL be accepted: latch A and B into internal registers, clear Sum and Error to 0, set cnt=0, and go to CALC.
REQ-013 start SHALL be ignored while in CALC, and A/B changes after acceptance SHALL NOT affect the result.
REQ-014 In CALC, each edge SHALL write the adder result for lane cnt into Sum[4cnt+3:4cnt], OR that lane's overflow into Error, and increment cnt.
REQ-015 Lane overflow SHALL be flagged when both operand lanes have equal sign bits and the 4-bit sum sign differs from them.
REQ-016 On lane overflow, the lane result SHALL be 4'b0111 if both operand sign bits are 0, and 4'b1000 if both are 1.
REQ-017 Without overflow, the lane result SHALL be the 4-bit wrapped sum.
REQ-018 No carry SHALL propagate between lanes.
REQ-019 On the edge that writes lane 3 (cnt=3), the FSM SHALL go to DONE, and cnt wrap to 0 SHALL NOT start another lane.
REQ-020 DONE SHALL last one cycle, with done=1; the next state SHALL be CALC if start=1 (back-to-back), else IDLE.
REQ-021 Latency SHALL be: acceptance edge E0, lanes written at E1..E4, done=1 during the cycle following E4.
REQ-022 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE; busy and done SHALL never be high together.
REQ-023 Sum and Error SHALL hold their last values in DONE and IDLE until the next accepted start.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, cnt=0, busy=0, done=0, Sum=16'h0000, Error=0, and clear the operand registers.
REQ-025 rst SHALL take priority over start and over any in-progress CALC; an interrupted operation SHALL produce no done pulse.
REQ-026 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-027 A=16'h1234, B=16'h1111, start pulse -> busy high 4 cycles, then done pulse with Sum=16'h2345, Error=0.
REQ-028 A=16'h7000, B=16'h1000 -> Sum=16'h7000, Error=1; and A=16'h8888, B=16'h8888 -> Sum=16'h8888, Error=1.
REQ-029 A=16'h00FF, B=16'h0011 -> Sum=16'h0000, Error=0 (no inter-lane carry); A=16'h0070, B=16'h0F90 -> Sum=16'h0F00, Error=0 (lane 1: 7+(-7)=0; no lane overflows).
REQ-030 Start held high continuously, with A/B changed mid-CALC -> the result matches the operands latched at acceptance, and a new operation begins directly from DONE with no IDLE cycle.
REQ-031 rst asserted at the edge after lane 1 is written -> no done pulse, Sum=16'h0000, Error=0, busy=0 on the following cycle.
REQ-032 Checker: every done pulse SHALL be compared against a per-lane saturating reference model, with busy/done mutual exclusion asserted every cycle.

Source files
------------

// File: rtl/paddsb_seq.sv
// paddsb_seq: packed signed saturating add of four 4-bit lanes.
// A single saturating adder is time-shared across the lanes, one lane per
// cycle, starting at lane 0. The result is presented with a one-cycle done pulse.

// Single-lane signed saturating adder (no carry in or out).
module paddsb_sat_add #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] s,
    output logic              ovf
);
    logic [LANE_W-1:0] raw;

    // Wrapped sum, overflow detect on sign mismatch, clamp toward the operand sign
    always_comb begin
        raw = a + b;
        ovf = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
        if (!ovf)
            s = raw;
        else if (a[LANE_W-1])
            s = {1'b1, {(LANE_W-1){1'b0}}};
        else
            s = {1'b0, {(LANE_W-1){1'b1}}};
    end
endmodule

module paddsb_seq #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_LANES*LANE_W-1:0] A,
    input  logic [NUM_LANES*LANE_W-1:0] B,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_LANES*LANE_W-1:0] Sum,
    output logic                        Error
);
    localparam int CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [NUM_LANES-1:0][LANE_W-1:0] lanes_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lanes_t           a_q, a_d;
    lanes_t           b_q, b_d;
    lanes_t           sum_q, sum_d;
    logic             err_q, err_d;

    logic [LANE_W-1:0] lane_s;
    logic              lane_ovf;

    // The one shared adder sees the lane selected by the counter
    paddsb_sat_add #(.LANE_W(LANE_W)) u_add (
        .a   (a_q[cnt_q]),
        .b   (b_q[cnt_q]),
        .s   (lane_s),
        .ovf (lane_ovf)
    );

    // Next-state, operand latch and per-lane result accumulation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Operands are captured here so later A/B changes are invisible
                    a_d     = A;
                    b_d     = B;
                    sum_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                sum_d[cnt_q] = lane_s;
                err_d        = err_q | lane_ovf;
                cnt_d        = cnt_q + CNT_W'(1);
                // Last lane written: stop here so the counter wrap never starts lane 0 again
                if (cnt_q == CNT_W'(NUM_LANES - 1))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything including the operand copies
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    // Status and results are direct views of the registered state
    always_comb begin
        busy  = (state_q == CALC);
        done  = (state_q == DONE);
        Sum   = sum_q;
        Error = err_q;
    end
endmodule
